reg_bus_arbiter: RTL and testbench



---
 rtl/reg_bus_arbiter_if.sv | 37 +++
 rtl/reg_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_arbiter_if.sv
// Debug register bus between the two masters, the arbiter and the two targets.
// The arbiter connects through the slave modport; the master modport is the environment side.
interface reg_bus_arbiter_if;
  logic        m0_req, m1_req;
  logic        m0_we, m1_we;
  logic        m0_tgt, m1_tgt;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_done, m1_done;
  logic [31:0] m_rd_data;
  logic        m_err;
  logic [7:0]  t_addr;
  logic [31:0] t_wdata;
  logic        t_wr_en_mem, t_rd_en_mem, t_wr_en_risc, t_rd_en_risc;
  logic [31:0] t_rd_data_mem, t_rd_data_risc;
  logic        t_rd_done_mem, t_rd_done_risc;
  logic        busy;
  logic [1:0]  cur_state;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_tgt, m1_tgt,
    input  m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  t_rd_data_mem, t_rd_data_risc, t_rd_done_mem, t_rd_done_risc,
    output m0_done, m1_done, m_rd_data, m_err, t_addr, t_wdata,
    output t_wr_en_mem, t_rd_en_mem, t_wr_en_risc, t_rd_en_risc,
    output busy, cur_state
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_tgt, m1_tgt,
    output m0_addr, m1_addr, m0_wdata, m1_wdata,
    output t_rd_data_mem, t_rd_data_risc, t_rd_done_mem, t_rd_done_risc,
    input  m0_done, m1_done, m_rd_data, m_err, t_addr, t_wdata,
    input  t_wr_en_mem, t_rd_en_mem, t_wr_en_risc, t_rd_en_risc,
    input  busy, cur_state
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin two-master, two-target arbiter for the 25 MHz debug register bus.
// Define REG_ARB_TIMEOUT_EN to abort reads that see no rd_done within TIMEOUT_CYCLES clocks.
module reg_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input logic              clk_25mhz,
  input logic              rst_i,
  reg_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        tgt_q, tgt_d;
  logic        gsel_q, gsel_d;
  logic        lastGrant_q, lastGrant_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdData_q, rdData_d;
  logic        winner;
  logic        selRdDone;
  logic [31:0] selRdData;
  logic        timeoutHit;

  // On contention the master that was not granted last time wins.
  assign winner    = (bus.m0_req && bus.m1_req) ? ~lastGrant_q : bus.m1_req;
  assign selRdDone = tgt_q ? bus.t_rd_done_risc : bus.t_rd_done_mem;
  assign selRdData = tgt_q ? bus.t_rd_data_risc : bus.t_rd_data_mem;

  always_ff @(posedge clk_25mhz or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      tgt_q       <= 1'b0;
      gsel_q      <= 1'b0;
      lastGrant_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdData_q    <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      tgt_q       <= tgt_d;
      gsel_q      <= gsel_d;
      lastGrant_q <= lastGrant_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdData_q    <= rdData_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    tgt_d       = tgt_q;
    gsel_d      = gsel_q;
    lastGrant_d = lastGrant_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdData_d    = rdData_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          gsel_d  = winner;
          we_d    = winner ? bus.m1_we    : bus.m0_we;
          tgt_d   = winner ? bus.m1_tgt   : bus.m0_tgt;
          addr_d  = winner ? bus.m1_addr  : bus.m0_addr;
          wdata_d = winner ? bus.m1_wdata : bus.m0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else if (selRdDone) begin
          rdData_d = selRdData;
          state_d  = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A real response on the expiry cycle takes priority over the timeout.
        if (selRdDone) begin
          rdData_d = selRdData;
          state_d  = DONE;
        end else if (timeoutHit) begin
          rdData_d = TIMEOUT_DATA;
          state_d  = DONE;
        end
      end
      DONE: begin
        lastGrant_d = gsel_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef REG_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  assign timeoutHit = (state_q == WAIT) && !selRdDone && (cnt_q >= 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_25mhz or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (state_q == WAIT) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (timeoutHit) err_d = 1'b1;
    end
  end

  assign bus.m_err = (state_q == DONE) && err_q;
`else
  logic [15:0] unusedCfg;
  assign unusedCfg  = 16'(TIMEOUT_CYCLES);
  assign timeoutHit = 1'b0;
  assign bus.m_err  = 1'b0;
`endif

  assign bus.t_wr_en_mem  = (state_q == ISSUE) &&  we_q && !tgt_q;
  assign bus.t_rd_en_mem  = (state_q == ISSUE) && !we_q && !tgt_q;
  assign bus.t_wr_en_risc = (state_q == ISSUE) &&  we_q &&  tgt_q;
  assign bus.t_rd_en_risc = (state_q == ISSUE) && !we_q &&  tgt_q;
  assign bus.m0_done      = (state_q == DONE) && !gsel_q;
  assign bus.m1_done      = (state_q == DONE) &&  gsel_q;
  assign bus.m_rd_data    = rdData_q;
  assign bus.t_addr       = addr_q;
  assign bus.t_wdata      = wdata_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.cur_state    = state_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: directed session table, reset corner case and
// randomized sessions against a transaction-level model (round-robin order, latencies, read data).
module tb_reg_bus_arbiter;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic clk_25mhz = 1'b0;
  logic rst_i;

  reg_bus_arbiter_if bus();

  reg_bus_arbiter #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_DATA  (TO_DATA)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .rst_i    (rst_i),
    .bus      (bus)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  // One session: requested masters, their transactions, target behaviour, expected results.
  // lat = cycles from strobe to rd_done; a negative lat means the target never answers.
  typedef struct {
    logic [1:0]  req;
    logic        we0, tgt0, we1, tgt1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1, tdata0, tdata1;
    int          lat0, lat1;
    logic        stray;
    logic        expFirst;
    logic [31:0] expRd;
  } vec_t;

  int          checks;
  int          failures;
  int          lastWinner;
  logic [31:0] expRd;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {bus.t_wr_en_mem, bus.t_rd_en_mem, bus.t_wr_en_risc, bus.t_rd_en_risc};
  endfunction

  // {wr_mem, rd_mem, wr_risc, rd_risc}; tgt 0 = memory loader, 1 = RISC core.
  function automatic logic [3:0] expStrobe(input logic we, input logic tgt);
    if (we) return tgt ? 4'b0010 : 4'b1000;
    return tgt ? 4'b0001 : 4'b0100;
  endfunction

  // Model: service order and final read data of a session, from the round-robin rule.
  function automatic void predict(inout vec_t v);
    logic first;
    logic second;
    logic [31:0] rd;
    first  = (v.req == 2'b11) ? logic'(lastWinner == 0) : v.req[1];
    second = ~first;
    rd     = expRd;
    for (int i = 0; i < ((v.req == 2'b11) ? 2 : 1); i++) begin
      logic g;
      g = (i == 0) ? first : second;
      if (!(g ? v.we1 : v.we0))
        rd = ((g ? v.lat1 : v.lat0) < 0) ? TO_DATA : (g ? v.tdata1 : v.tdata0);
    end
    v.expFirst = first;
    v.expRd    = rd;
  endfunction

  task automatic clearTargets();
    bus.t_rd_done_mem  = 1'b0;
    bus.t_rd_done_risc = 1'b0;
    bus.t_rd_data_mem  = 32'h0;
    bus.t_rd_data_risc = 32'h0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int   order[$];
    int   firstDone;
    logic we, tgt;
    logic [7:0]  addr;
    logic [31:0] wdata, tdata;
    int   lat;
    if (v.stray) begin
      bus.t_rd_done_mem  = 1'b1;
      bus.t_rd_done_risc = 1'b1;
      bus.t_rd_data_mem  = 32'h5A5A_0001;
      bus.t_rd_data_risc = 32'h5A5A_0002;
      tick();
      clearTargets();
      checkOutput("idle stray done", 32'({bus.m1_done, bus.m0_done}), 32'd0);
      checkOutput("idle stray state", 32'(bus.cur_state), 32'd0);
      checkOutput("idle stray rdata", bus.m_rd_data, expRd);
    end
    bus.m0_we = v.we0; bus.m0_tgt = v.tgt0; bus.m0_addr = v.addr0; bus.m0_wdata = v.wdata0;
    bus.m1_we = v.we1; bus.m1_tgt = v.tgt1; bus.m1_addr = v.addr1; bus.m1_wdata = v.wdata1;
    bus.m0_req = v.req[0];
    bus.m1_req = v.req[1];
    if (v.req == 2'b11) begin
      order.push_back((lastWinner == 0) ? 1 : 0);
      order.push_back((lastWinner == 0) ? 0 : 1);
    end else begin
      order.push_back(v.req[1] ? 1 : 0);
    end
    firstDone = -1;
    foreach (order[i]) begin
      int g;
      g     = order[i];
      we    = (g == 1) ? v.we1    : v.we0;
      tgt   = (g == 1) ? v.tgt1   : v.tgt0;
      addr  = (g == 1) ? v.addr1  : v.addr0;
      wdata = (g == 1) ? v.wdata1 : v.wdata0;
      tdata = (g == 1) ? v.tdata1 : v.tdata0;
      lat   = (g == 1) ? v.lat1   : v.lat0;
      tick();
      checkOutput("issue strobe", 32'(strobes()), 32'(expStrobe(we, tgt)));
      checkOutput("issue t_addr", 32'(bus.t_addr), 32'(addr));
      checkOutput("issue t_wdata", bus.t_wdata, wdata);
      checkOutput("issue state", 32'(bus.cur_state), 32'd1);
      checkOutput("issue busy", 32'(bus.busy), 32'd1);
      checkOutput("issue done", 32'({bus.m1_done, bus.m0_done}), 32'd0);
      if (we) begin
        if (v.stray) begin
          bus.t_rd_done_mem  = 1'b1;
          bus.t_rd_done_risc = 1'b1;
          bus.t_rd_data_mem  = 32'h5A5A_0003;
          bus.t_rd_data_risc = 32'h5A5A_0004;
        end
        tick();
      end else if (lat < 0) begin
        for (int c = 0; c < 9; c++) begin
          tick();
          checkOutput("silent wait state", 32'(bus.cur_state), 32'd2);
          checkOutput("silent wait done", 32'({bus.m1_done, bus.m0_done}), 32'd0);
        end
        tick();
        expRd = TO_DATA;
      end else begin
        for (int c = 0; c < lat; c++) begin
          if (tgt) bus.t_rd_data_risc = ~tdata; else bus.t_rd_data_mem = ~tdata;
          if (v.stray) begin
            if (tgt) begin bus.t_rd_done_mem = 1'b1; bus.t_rd_data_mem = 32'h5A5A_5A5A; end
            else begin bus.t_rd_done_risc = 1'b1; bus.t_rd_data_risc = 32'h5A5A_5A5A; end
          end
          tick();
          clearTargets();
          checkOutput("wait state", 32'(bus.cur_state), 32'd2);
          checkOutput("wait done", 32'({bus.m1_done, bus.m0_done}), 32'd0);
          checkOutput("wait strobe", 32'(strobes()), 32'd0);
        end
        if (tgt) begin bus.t_rd_done_risc = 1'b1; bus.t_rd_data_risc = tdata; end
        else begin bus.t_rd_done_mem = 1'b1; bus.t_rd_data_mem = tdata; end
        tick();
        expRd = tdata;
      end
      clearTargets();
      checkOutput("done pulse", 32'({bus.m1_done, bus.m0_done}), (g == 1) ? 32'd2 : 32'd1);
      checkOutput("done rdata", bus.m_rd_data, expRd);
      checkOutput("done err", 32'(bus.m_err), (!we && lat < 0) ? 32'd1 : 32'd0);
      checkOutput("done state", 32'(bus.cur_state), 32'd3);
      checkOutput("done strobe", 32'(strobes()), 32'd0);
      checkOutput("done t_addr", 32'(bus.t_addr), 32'(addr));
      checkOutput("done t_wdata", bus.t_wdata, wdata);
      if (i == 0) firstDone = bus.m1_done ? 1 : 0;
      if (g == 1) bus.m1_req = 1'b0; else bus.m0_req = 1'b0;
      lastWinner = g;
      tick();
      checkOutput("post idle state", 32'(bus.cur_state), 32'd0);
      checkOutput("post idle done", 32'({bus.m1_done, bus.m0_done}), 32'd0);
      checkOutput("post idle busy", 32'(bus.busy), 32'd0);
    end
    checkOutput("first grant", 32'(firstDone), 32'(v.expFirst));
    checkOutput("session rdata", bus.m_rd_data, v.expRd);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " state"}, 32'(bus.cur_state), 32'd0);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " strobe"}, 32'(strobes()), 32'd0);
    checkOutput({tag, " done"}, 32'({bus.m1_done, bus.m0_done}), 32'd0);
    checkOutput({tag, " err"}, 32'(bus.m_err), 32'd0);
    checkOutput({tag, " rdata"}, bus.m_rd_data, 32'd0);
    checkOutput({tag, " t_addr"}, 32'(bus.t_addr), 32'd0);
    checkOutput({tag, " t_wdata"}, bus.t_wdata, 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v;
    checks = 0;
    failures = 0;
    vecs[0] = '{default: '0, req: 2'b01, we0: 1'b1, tgt0: 1'b1, addr0: 8'h10,
                wdata0: 32'h1234_5678, expFirst: 1'b0, expRd: 32'h0};
    vecs[1] = '{default: '0, req: 2'b10, we1: 1'b0, tgt1: 1'b0, addr1: 8'h04, lat1: 3,
                tdata1: 32'hCAFE_0001, stray: 1'b1, expFirst: 1'b1, expRd: 32'hCAFE_0001};
    vecs[2] = '{default: '0, req: 2'b11, we0: 1'b1, tgt0: 1'b0, addr0: 8'h20, wdata0: 32'hAAAA_5555,
                we1: 1'b0, tgt1: 1'b1, addr1: 8'h21, lat1: 0, tdata1: 32'h0BAD_F00D,
                expFirst: 1'b0, expRd: 32'h0BAD_F00D};
    vecs[3] = '{default: '0, req: 2'b11, we0: 1'b0, tgt0: 1'b1, addr0: 8'h30, lat0: 2,
                tdata0: 32'h1111_2222, we1: 1'b1, tgt1: 1'b1, addr1: 8'h31, wdata1: 32'h3333_4444,
                stray: 1'b1, expFirst: 1'b0, expRd: 32'h1111_2222};
    vecs[4] = '{default: '0, req: 2'b10, we1: 1'b1, tgt1: 1'b0, addr1: 8'hFF,
                wdata1: 32'hFFFF_FFFF, stray: 1'b1, expFirst: 1'b1, expRd: 32'h1111_2222};
    vecs[5] = '{default: '0, req: 2'b01, we0: 1'b0, tgt0: 1'b0, addr0: 8'h00, lat0: 1,
                tdata0: 32'h8000_0001, stray: 1'b1, expFirst: 1'b0, expRd: 32'h8000_0001};

    rst_i = 1'b0;
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    bus.m0_we = 1'b0; bus.m1_we = 1'b0; bus.m0_tgt = 1'b0; bus.m1_tgt = 1'b0;
    bus.m0_addr = 8'h0; bus.m1_addr = 8'h0; bus.m0_wdata = 32'h0; bus.m1_wdata = 32'h0;
    clearTargets();
    lastWinner = 1;
    expRd = 32'h0;
    tick();
    tick();
    checkResetValues("reset");
    rst_i = 1'b1;
    tick();
    checkResetValues("after reset");

    foreach (vecs[i]) applyStimulus(vecs[i]);

`ifdef REG_ARB_TIMEOUT_EN
    v = '{default: '0, req: 2'b10, we1: 1'b0, tgt1: 1'b1, addr1: 8'h44, lat1: -1,
          expFirst: 1'b1, expRd: 32'hDEAD_BEEF};
    applyStimulus(v);
    v = '{default: '0, req: 2'b01, we0: 1'b0, tgt0: 1'b0, addr0: 8'h45, lat0: 9,
          tdata0: 32'h7777_0009, expFirst: 1'b0, expRd: 32'h7777_0009};
    applyStimulus(v);
`endif

    // Reset in the middle of a read that is still waiting for its target.
    bus.m0_we = 1'b0; bus.m0_tgt = 1'b1; bus.m0_addr = 8'h33; bus.m0_wdata = 32'h9999_0000;
    bus.m0_req = 1'b1;
    tick();
    tick();
    checkOutput("pre-reset wait state", 32'(bus.cur_state), 32'd2);
    #10 rst_i = 1'b0;
    #1 checkResetValues("mid reset");
    bus.m0_req = 1'b0;
    tick();
    checkOutput("held reset done", 32'({bus.m1_done, bus.m0_done}), 32'd0);
    rst_i = 1'b1;
    tick();
    checkResetValues("post reset");
    lastWinner = 1;
    expRd = 32'h0;
    v = '{default: '0, req: 2'b11, we0: 1'b0, tgt0: 1'b1, addr0: 8'h50, lat0: 1,
          tdata0: 32'h5050_5050, we1: 1'b1, tgt1: 1'b0, addr1: 8'h51, wdata1: 32'h5151_5151,
          expFirst: 1'b0, expRd: 32'h5050_5050};
    applyStimulus(v);

    for (int it = 0; it < 40; it++) begin
      v = '{default: '0};
      v.req    = 2'($urandom_range(1, 3));
      v.we0    = 1'($urandom);
      v.tgt0   = 1'($urandom);
      v.we1    = 1'($urandom);
      v.tgt1   = 1'($urandom);
      v.addr0  = 8'($urandom);
      v.addr1  = 8'($urandom);
      v.wdata0 = $urandom;
      v.wdata1 = $urandom;
      v.tdata0 = $urandom;
      v.tdata1 = $urandom;
      v.lat0   = int'($urandom_range(0, 4));
      v.lat1   = int'($urandom_range(0, 4));
      v.stray  = 1'($urandom);
`ifdef REG_ARB_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) v.lat0 = -1;
`endif
      predict(v);
      applyStimulus(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
